// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_dac_start_ctrl_if
// Brief    : Control/status bundle between the register map and the DAC
//            start controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ad_ip_jesd204_tpl_dac_start_ctrl_if #(
    parameter int NUM_CHANNELS = 2
);
    logic                    arm;
    logic                    stop;
    logic                    ext_sync_en;
    logic                    dac_external_sync;
    logic                    link_ready;
    logic                    dac_dunf;
    logic [NUM_CHANNELS-1:0] channel_enable;
    logic [NUM_CHANNELS-1:0] dac_valid;
    logic                    dds_reset;
    logic                    data_mute;
    logic [1:0]              state;
    logic [15:0]             unf_count;
    logic                    sync_timeout;

    modport master (
        output arm, stop, ext_sync_en, dac_external_sync, link_ready,
               dac_dunf, channel_enable,
        input  dac_valid, dds_reset, data_mute, state, unf_count, sync_timeout
    );

    modport slave (
        input  arm, stop, ext_sync_en, dac_external_sync, link_ready,
               dac_dunf, channel_enable,
        output dac_valid, dds_reset, data_mute, state, unf_count, sync_timeout
    );
endinterface
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_dac_start_ctrl
// Brief    : Gates DAC sample flow on arm / external sync / link ready and
//            counts DMA underflows. Optional ARMED timeout enabled by the
//            TPL_DAC_SYNC_TIMEOUT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_start_ctrl #(
    parameter int NUM_CHANNELS = 2,
    parameter int SYNC_TIMEOUT = 65536
) (
    input  wire logic                          link_clk,
    input  wire logic                          link_resetn,
    ad_ip_jesd204_tpl_dac_start_ctrl_if.slave  ctrl
);

    localparam logic [1:0] c_idle   = 2'b00;
    localparam logic [1:0] c_armed  = 2'b01;
    localparam logic [1:0] c_synced = 2'b10;
    localparam logic [1:0] c_run    = 2'b11;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_dds_reset;
    logic        r_data_mute;
    logic        r_sync_d;
    logic        w_sync_edge;
    logic        w_timeout;
    logic        w_resync;
    logic [15:0] r_unf_count;

    assign w_sync_edge = ctrl.dac_external_sync & ~r_sync_d;
    assign w_resync    = ctrl.arm & ~ctrl.stop;

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            r_sync_d <= 1'b0;
        end else begin
            r_sync_d <= ctrl.dac_external_sync;
        end
    end

`ifdef TPL_DAC_SYNC_TIMEOUT_EN
    localparam logic [23:0] c_timeout_last = 24'(SYNC_TIMEOUT - 1);

    logic [23:0] r_wait_cnt;
    logic        r_sync_timeout;

    assign w_timeout = (r_state == c_armed) && (r_wait_cnt == c_timeout_last);

    // Every ARMED entry goes through arm, so clearing on arm restarts the wait.
    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            r_wait_cnt     <= '0;
            r_sync_timeout <= 1'b0;
        end else if (w_resync) begin
            r_wait_cnt     <= '0;
            r_sync_timeout <= 1'b0;
        end else if (r_state == c_armed) begin
            r_wait_cnt <= r_wait_cnt + 24'd1;
            if (w_timeout && !w_sync_edge && !ctrl.stop) begin
                r_sync_timeout <= 1'b1;
            end
        end
    end

    assign ctrl.sync_timeout = r_sync_timeout;
`else
    assign w_timeout         = 1'b0;
    assign ctrl.sync_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (ctrl.stop) begin
            w_state_nxt = c_idle;
        end else if (ctrl.arm) begin
            w_state_nxt = ctrl.ext_sync_en ? c_armed : c_synced;
        end else begin
            case (r_state)
                c_armed: begin
                    if (w_sync_edge) begin
                        w_state_nxt = c_synced;
                    end else if (w_timeout) begin
                        w_state_nxt = c_idle;
                    end
                end
                c_synced: begin
                    if (ctrl.link_ready) begin
                        w_state_nxt = c_run;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Mute/DDS-reset flops reset to 1 so assertion of link_resetn mutes at once.
    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            r_state     <= c_idle;
            r_dds_reset <= 1'b1;
            r_data_mute <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_dds_reset <= (w_state_nxt != c_run);
            r_data_mute <= (w_state_nxt != c_run);
        end
    end

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            r_unf_count <= '0;
        end else if (!ctrl.stop) begin
            if (ctrl.arm) begin
                r_unf_count <= '0;
            end else if ((r_state == c_run) && ctrl.link_ready && ctrl.dac_dunf &&
                         (r_unf_count != 16'hFFFF)) begin
                r_unf_count <= r_unf_count + 16'd1;
            end
        end
    end

    assign ctrl.state     = r_state;
    assign ctrl.dds_reset = r_dds_reset;
    assign ctrl.data_mute = r_data_mute;
    assign ctrl.unf_count = r_unf_count;
    assign ctrl.dac_valid = (r_state == c_run) ?
                            (ctrl.channel_enable & {NUM_CHANNELS{ctrl.link_ready}}) :
                            '0;

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_dac_start_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ad_ip_jesd204_tpl_dac_start_ctrl
// Brief    : Directed bench with a cycle-level reference model of the start
//            controller; honours TPL_DAC_SYNC_TIMEOUT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad_ip_jesd204_tpl_dac_start_ctrl;

    localparam int NCH = 2;
    localparam int STO = 16;

    logic link_clk    = 1'b0;
    logic link_resetn = 1'b0;

    ad_ip_jesd204_tpl_dac_start_ctrl_if #(.NUM_CHANNELS(NCH)) ctrl ();

    ad_ip_jesd204_tpl_dac_start_ctrl #(
        .NUM_CHANNELS (NCH),
        .SYNC_TIMEOUT (STO)
    ) u_dut (
        .link_clk    (link_clk),
        .link_resetn (link_resetn),
        .ctrl        (ctrl)
    );

    always #5 link_clk = ~link_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=waiting for sync 2=waiting for link 3=running
`ifdef TPL_DAC_SYNC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    int          m_phase     = 0;
    int          m_waited    = 0;
    int          m_unf       = 0;
    logic        m_flag      = 1'b0;
    logic        m_sync_prev = 1'b0;

    task automatic model_reset();
        m_phase     = 0;
        m_waited    = 0;
        m_unf       = 0;
        m_flag      = 1'b0;
        m_sync_prev = 1'b0;
    endtask

    task automatic model_step();
        bit rising;
        rising      = ctrl.dac_external_sync && !m_sync_prev;
        m_sync_prev = ctrl.dac_external_sync;
        if (ctrl.stop) begin
            m_phase = 0;
        end else if (ctrl.arm) begin
            m_phase  = ctrl.ext_sync_en ? 1 : 2;
            m_unf    = 0;
            m_flag   = 1'b0;
            m_waited = 0;
        end else if (m_phase == 1) begin
            if (rising) begin
                m_phase = 2;
            end else if (TO_EN && (m_waited + 1 == STO)) begin
                m_phase = 0;
                m_flag  = 1'b1;
            end else begin
                m_waited++;
            end
        end else if (m_phase == 2) begin
            if (ctrl.link_ready) m_phase = 3;
        end else if (m_phase == 3) begin
            if (ctrl.link_ready && ctrl.dac_dunf && m_unf < 65535) m_unf++;
        end
    endtask

    initial begin
        forever begin
            @(posedge link_clk or negedge link_resetn);
            if (!link_resetn) model_reset();
            else              model_step();
        end
    end

    initial begin
        logic [NCH-1:0] ev;
        forever begin
            @(negedge link_clk);
            for (int i = 0; i < NCH; i++) begin
                ev[i] = (m_phase == 3) && ctrl.channel_enable[i] && ctrl.link_ready;
            end
            chk("model_state",     32'(ctrl.state),        32'(m_phase));
            chk("model_dac_valid", 32'(ctrl.dac_valid),    32'(ev));
            chk("model_dds_reset", 32'(ctrl.dds_reset),    32'(m_phase != 3));
            chk("model_data_mute", 32'(ctrl.data_mute),    32'(m_phase != 3));
            chk("model_unf_count", 32'(ctrl.unf_count),    32'(m_unf));
            chk("model_sync_to",   32'(ctrl.sync_timeout), 32'(m_flag));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge link_clk);
            #1;
        end
    endtask

    initial begin
        ctrl.arm               = 1'b0;
        ctrl.stop              = 1'b0;
        ctrl.ext_sync_en       = 1'b0;
        ctrl.dac_external_sync = 1'b1;
        ctrl.link_ready        = 1'b0;
        ctrl.dac_dunf          = 1'b0;
        ctrl.channel_enable    = '0;

        step(3);
        chk("rst_state",     32'(ctrl.state),        32'h0);
        chk("rst_dds_reset", 32'(ctrl.dds_reset),    32'h1);
        chk("rst_mute",      32'(ctrl.data_mute),    32'h1);
        chk("rst_valid",     32'(ctrl.dac_valid),    32'h0);
        chk("rst_unf",       32'(ctrl.unf_count),    32'h0);
        chk("rst_sync_to",   32'(ctrl.sync_timeout), 32'h0);
        link_resetn = 1'b1;
        step(2);
        chk("release_idle", 32'(ctrl.state), 32'h0);
        ctrl.dac_external_sync = 1'b0;

        // immediate start
        ctrl.ext_sync_en    = 1'b0;
        ctrl.link_ready     = 1'b1;
        ctrl.channel_enable = 2'b11;
        ctrl.arm            = 1'b1;
        step();
        ctrl.arm = 1'b0;
        chk("imm_cyc1_state", 32'(ctrl.state), 32'h2);
        step();
        chk("imm_cyc2_state", 32'(ctrl.state),     32'h3);
        chk("imm_cyc2_valid", 32'(ctrl.dac_valid), 32'h3);
        chk("imm_cyc2_dds",   32'(ctrl.dds_reset), 32'h0);
        chk("imm_cyc2_mute",  32'(ctrl.data_mute), 32'h0);

        // underflow with link_ready 1,0,1
        ctrl.dac_dunf = 1'b1;
        step();
        ctrl.link_ready = 1'b0;
        step();
        ctrl.link_ready = 1'b1;
        step();
        ctrl.dac_dunf = 1'b0;
        chk("unf_two", 32'(ctrl.unf_count), 32'h2);

        // stop beats arm
        ctrl.stop = 1'b1;
        ctrl.arm  = 1'b1;
        step();
        ctrl.stop = 1'b0;
        ctrl.arm  = 1'b0;
        chk("prio_state", 32'(ctrl.state),     32'h0);
        chk("prio_unf",   32'(ctrl.unf_count), 32'h2);

        // restart, one underflow, then resync into ARMED
        ctrl.arm = 1'b1;
        step();
        ctrl.arm = 1'b0;
        step();
        chk("restart_state", 32'(ctrl.state),     32'h3);
        chk("restart_unf",   32'(ctrl.unf_count), 32'h0);
        ctrl.dac_dunf = 1'b1;
        step();
        ctrl.dac_dunf = 1'b0;
        chk("unf_one", 32'(ctrl.unf_count), 32'h1);
        ctrl.ext_sync_en = 1'b1;
        ctrl.arm         = 1'b1;
        step();
        ctrl.arm = 1'b0;
        chk("resync_state", 32'(ctrl.state),     32'h1);
        chk("resync_unf",   32'(ctrl.unf_count), 32'h0);

        // external sync with link held off
        ctrl.stop = 1'b1;
        step();
        ctrl.stop       = 1'b0;
        ctrl.link_ready = 1'b0;
        ctrl.arm        = 1'b1;
        step();
        ctrl.arm = 1'b0;
        step(4);
        chk("ext_wait_state", 32'(ctrl.state), 32'h1);
        ctrl.dac_external_sync = 1'b1;
        step();
        ctrl.dac_external_sync = 1'b0;
        chk("ext_synced", 32'(ctrl.state), 32'h2);
        step(3);
        chk("ext_hold_state", 32'(ctrl.state),     32'h2);
        chk("ext_hold_valid", 32'(ctrl.dac_valid), 32'h0);
        ctrl.link_ready = 1'b1;
        step();
        chk("ext_run_state", 32'(ctrl.state),     32'h3);
        chk("ext_run_valid", 32'(ctrl.dac_valid), 32'h3);

        // ARMED timeout
        ctrl.stop = 1'b1;
        step();
        ctrl.stop = 1'b0;
        ctrl.arm  = 1'b1;
        step();
        ctrl.arm = 1'b0;
        step(15);
        chk("to_cyc16_state", 32'(ctrl.state),        32'h1);
        chk("to_cyc16_flag",  32'(ctrl.sync_timeout), 32'h0);
        step();
`ifdef TPL_DAC_SYNC_TIMEOUT_EN
        chk("to_expired_state", 32'(ctrl.state),        32'h0);
        chk("to_expired_flag",  32'(ctrl.sync_timeout), 32'h1);
`else
        chk("to_disabled_state", 32'(ctrl.state),        32'h1);
        chk("to_disabled_flag",  32'(ctrl.sync_timeout), 32'h0);
`endif
        ctrl.stop = 1'b1;
        step();
        ctrl.stop = 1'b0;
        chk("to_flag_kept", 32'(ctrl.sync_timeout), 32'(TO_EN));
        ctrl.arm = 1'b1;
        step();
        ctrl.arm = 1'b0;
        chk("to_flag_cleared", 32'(ctrl.sync_timeout), 32'h0);
        step(15);
        ctrl.dac_external_sync = 1'b1;
        step();
        ctrl.dac_external_sync = 1'b0;
        chk("to_edge_wins_state", 32'(ctrl.state),        32'h2);
        chk("to_edge_wins_flag",  32'(ctrl.sync_timeout), 32'h0);

        // saturation: 0xFFFE then three more underflows
        ctrl.stop = 1'b1;
        step();
        ctrl.stop        = 1'b0;
        ctrl.ext_sync_en = 1'b0;
        ctrl.arm         = 1'b1;
        step();
        ctrl.arm = 1'b0;
        step();
        ctrl.dac_dunf = 1'b1;
        step(65534);
        chk("sat_fffe", 32'(ctrl.unf_count), 32'hFFFE);
        step(3);
        ctrl.dac_dunf = 1'b0;
        chk("sat_ffff", 32'(ctrl.unf_count), 32'hFFFF);

        // asynchronous reset in RUN
        chk("pre_rst_valid", 32'(ctrl.dac_valid), 32'h3);
        #2;
        link_resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(ctrl.dac_valid), 32'h0);
        chk("arst_mute",  32'(ctrl.data_mute), 32'h1);
        chk("arst_state", 32'(ctrl.state),     32'h0);
        step(2);
        ctrl.dac_external_sync = 1'b1;
        link_resetn            = 1'b1;
        step(3);
        chk("post_arst_idle", 32'(ctrl.state), 32'h0);
        ctrl.dac_external_sync = 1'b0;
        step();
        ctrl.dac_external_sync = 1'b1;
        step();
        chk("idle_ignores_edge", 32'(ctrl.state), 32'h0);
        ctrl.arm = 1'b1;
        step();
        ctrl.arm = 1'b0;
        chk("post_arst_arm", 32'(ctrl.state), 32'h2);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ad_ip_jesd204_tpl_dac_start_ctrl.md
AD_IP_JESD204_TPL_DAC_START_CTRL -- requirements
Module: ad_ip_jesd204_tpl_dac_start_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2: number of converter channels gated.
REQ-002 SHALL have parameter SYNC_TIMEOUT, default 65536: link_clk cycles to wait in ARMED for external sync; range 2..2^24.
REQ-003 SHALL have port link_clk  in  1: the only clock. All logic is on this domain.
REQ-004 SHALL have port link_resetn  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port arm  in  1: single-cycle start/resync request from the register map.
REQ-006 SHALL have port stop  in  1: single-cycle stop request.
REQ-007 SHALL have port ext_sync_en  in  1: 1 = wait for an external sync edge; 0 = start immediately.
REQ-008 SHALL have port dac_external_sync  in  1: external sync, already synchronous to link_clk.
REQ-009 SHALL have port link_ready  in  1: downstream JESD link accepts data.
REQ-010 SHALL have port dac_dunf  in  1: DMA underflow flag.
REQ-011 SHALL have port channel_enable  in  NUM_CHANNELS: per-channel enables.
REQ-012 SHALL have port dac_valid  out  NUM_CHANNELS: per-channel sample request to the DMA.
REQ-013 SHALL have port dds_reset  out  1: holds DDS phase accumulators at their init values.
REQ-014 SHALL have port data_mute  out  1: forces the link data to zero.
REQ-015 SHALL have port state  out  2: encoded FSM state.
REQ-016 SHALL have port unf_count  out  16: underflow cycle counter.
REQ-017 SHALL have port sync_timeout  out  1: sticky flag, ARMED phase timed out.

Function
REQ-018 SHALL implement the FSM states IDLE=00, ARMED=01, SYNCED=10, RUN=11; state is driven from the state register.
REQ-019 SHALL define the external sync edge as dac_external_sync=1 with its 1-cycle registered copy =0. The copy updates every cycle.
REQ-020 SHALL take these transitions from IDLE on arm: to ARMED if ext_sync_en=1, otherwise to SYNCED. The transition happens on the next clock edge.
REQ-021 SHALL move from ARMED to SYNCED on the clock edge that samples a sync edge. Edges outside ARMED are ignored.
REQ-022 SHALL move from SYNCED to RUN on the first clock edge that samples link_ready=1.
REQ-023 SHALL go to IDLE on stop in any state; stop takes priority over arm, a sync edge and timeout.
REQ-024 SHALL treat arm in ARMED, SYNCED or RUN as a resync: the FSM re-enters ARMED or SYNCED according to ext_sync_en.
REQ-025 SHALL drive dds_reset=1 and data_mute=1 in every state except RUN, where both are 0.
REQ-026 SHALL drive dac_valid = channel_enable AND link_ready (replicated) when state=RUN, else 0. This path is combinational, with no added latency.
REQ-027 SHALL increment unf_count on each cycle with state=RUN, link_ready=1 and dac_dunf=1; unf_count saturates at 0xFFFF.
REQ-028 SHALL clear unf_count on arm; when clear and increment occur in the same cycle, the clear wins.
REQ-029 SHALL leave unf_count and sync_timeout unchanged on stop.

Reset
REQ-030 SHALL, while link_resetn=0, force state=IDLE, unf_count=0, sync_timeout=0 and the sync-edge register=0. Consequently dac_valid=0, dds_reset=1 and data_mute=1.
REQ-031 SHALL, on reset assertion in any state including RUN, drop dac_valid and raise data_mute asynchronously.
REQ-032 SHALL come out of reset in IDLE and require a fresh arm; a dac_external_sync held high at release is not an edge until it toggles.

Configuration
REQ-033 SHALL include the ARMED timeout logic only when TPL_DAC_SYNC_TIMEOUT_EN is defined.
REQ-034 SHALL, with TPL_DAC_SYNC_TIMEOUT_EN defined, clear a 24-bit counter on ARMED entry and increment it each ARMED cycle.
REQ-035 SHALL, with TPL_DAC_SYNC_TIMEOUT_EN defined, go to IDLE and set sync_timeout when the counter equals SYNC_TIMEOUT-1 and no sync edge is present; a sync edge in that same cycle wins. sync_timeout clears on arm.
REQ-036 SHALL, without TPL_DAC_SYNC_TIMEOUT_EN, wait in ARMED indefinitely and tie sync_timeout to 0.

Verification
REQ-037 SHALL cover immediate start: ext_sync_en=0, link_ready=1, channel_enable=2'b11, arm at cycle 0 -> state=10 at cycle 1, 11 at cycle 2, dac_valid=2'b11 and dds_reset=0 from cycle 2.
REQ-038 SHALL cover external sync: ext_sync_en=1, arm, sync rises 5 cycles later -> SYNCED on that edge; with link_ready=0 the FSM holds in SYNCED with dac_valid=0; link_ready=1 -> RUN next edge.
REQ-039 SHALL cover timeout (macro on, SYNC_TIMEOUT=16): arm, no sync -> IDLE and sync_timeout=1 after 16 ARMED cycles; a sync edge in cycle 16 -> SYNCED, flag stays 0.
REQ-040 SHALL cover underflow: in RUN, dac_dunf=1 for 3 cycles with link_ready toggling 1,0,1 -> unf_count=2; preload 0xFFFE plus 3 underflows -> 0xFFFF.
REQ-041 SHALL cover priority: stop and arm in the same RUN cycle -> IDLE, unf_count unchanged. Arm in RUN with ext_sync_en=1 -> ARMED, unf_count=0.
REQ-042 SHALL cover reset: link_resetn low mid-RUN -> dac_valid=0 and data_mute=1 immediately; after release state=00 until arm.
